requant_sat: RTL and testbench

Pipelined requantizer that consumes the one-bit-widened two's-complement sum produced by the fixed-point adder and returns it to a narrower working format for the EKF datapath. It rounds away surplus fraction bits, saturates on integer overflow, and tracks saturation events. A two-stage valid/ready pipeline lets it sit between the adder and the next register stage, such as the state/covariance update registers.

---
 rtl/ekf_fxp_pkg.sv | 35 +++
 rtl/requant_sat_if.sv | 28 ++
 rtl/fxp_clip.sv | 26 ++
 rtl/requant_sat.sv | 113 +++++++++++
 tb/tb_requant_sat.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ekf_fxp_pkg.sv
`default_nettype none
// ============================================================================
// ekf_fxp_pkg : fixed-point format helpers shared by EKF datapath stages
// Rev 1.0
// ============================================================================
package ekf_fxp_pkg;

  // Width of an adder sum: operand format widened by one carry bit.
  function automatic int fxp_sum_width(input int s, input int i, input int f);
    return s + i + f + 1;
  endfunction

  function automatic int fxp_fmt_width(input int s, input int i, input int f);
    return s + i + f;
  endfunction

  function automatic longint fxp_round_const(input int sh);
    return (sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0);
  endfunction

  function automatic longint fxp_pos_rail(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint fxp_neg_rail(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  function automatic bit fxp_requant_legal(input int s, input int i, input int f,
                                           input int oi, input int of);
    return (s == 1) && (oi >= 0) && (oi <= i + 1) && (of >= 0) && (of <= f);
  endfunction

endpackage
`default_nettype wire

// File: rtl/requant_sat_if.sv
`default_nettype none
// ============================================================================
// requant_sat_if : input/output valid-ready streams of the requantizer
// Rev 1.0
// ============================================================================
interface requant_sat_if #(
  parameter int IW = 25,
  parameter int OW = 20
);
  logic [IW-1:0] din;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic          sat_now;

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, sat_now
  );

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, sat_now
  );
endinterface
`default_nettype wire

// File: rtl/fxp_clip.sv
`default_nettype none
// ============================================================================
// fxp_clip : combinational signed clip of IN_W bits down to OUT_W bits
// Rev 1.0
// ============================================================================
module fxp_clip
  import ekf_fxp_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int OUT_W = 20
) (
  input  wire logic [IN_W-1:0]  i_val,
  output logic      [OUT_W-1:0] o_val,
  output logic                  o_sat
);
  localparam logic [OUT_W-1:0] c_POS = OUT_W'(fxp_pos_rail(OUT_W));
  localparam logic [OUT_W-1:0] c_NEG = OUT_W'(fxp_neg_rail(OUT_W));

  logic [IN_W-OUT_W:0] w_upper;

  // Value fits only if every bit from the output sign bit upward agrees.
  assign w_upper = i_val[IN_W-1:OUT_W-1];
  assign o_sat   = ~((&w_upper) | (~|w_upper));
  assign o_val   = o_sat ? (i_val[IN_W-1] ? c_NEG : c_POS) : i_val[OUT_W-1:0];
endmodule
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
// requant_sat : two-stage round + saturate requantizer with clip statistics
// Rev 1.0
// ============================================================================
module requant_sat
  import ekf_fxp_pkg::*;
#(
  parameter int SIGN_BIT    = 1,
  parameter int INT_BIT     = 7,
  parameter int FLT_BIT     = 16,
  parameter int OUT_INT_BIT = 7,
  parameter int OUT_FLT_BIT = 12
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  requant_sat_if.slave     bus,
  input  wire logic        clr_sat,
  output logic             sat_flag,
  output logic [15:0]      sat_cnt
);
  localparam int c_IW  = fxp_sum_width(SIGN_BIT, INT_BIT, FLT_BIT);
  localparam int c_OW  = fxp_fmt_width(SIGN_BIT, OUT_INT_BIT, OUT_FLT_BIT);
  localparam int c_SH  = FLT_BIT - OUT_FLT_BIT;
  localparam int c_S1W = c_IW + 1;

  generate
    if (!fxp_requant_legal(SIGN_BIT, INT_BIT, FLT_BIT, OUT_INT_BIT, OUT_FLT_BIT)) begin : g_fmt_illegal
      $error("requant_sat: illegal input/output format");
    end
  endgenerate

  logic                    w_adv;
  logic signed [c_S1W-1:0] w_ext;
  logic signed [c_S1W-1:0] w_s1_next;
  logic        [c_OW-1:0]  w_clip;
  logic                    w_clip_sat;
  logic                    w_sat_load;

  logic        [c_S1W-1:0] r_s1_val;
  logic                    r_s1_valid;
  logic        [c_OW-1:0]  r_dout;
  logic                    r_out_valid;
  logic                    r_sat_now;
  logic                    r_sat_flag;
  logic        [15:0]      r_sat_cnt;

  assign w_adv        = ~r_out_valid | bus.out_ready;
  assign bus.in_ready = w_adv & rst_n;
  assign w_ext        = {bus.din[c_IW-1], bus.din};

  generate
    if (c_SH > 0) begin : g_round
      logic signed [c_S1W-1:0] w_rnd;
      // Adding half an output LSB before the arithmetic shift rounds half toward +inf.
      assign w_rnd     = w_ext + $signed(c_S1W'(fxp_round_const(c_SH)));
      assign w_s1_next = w_rnd >>> c_SH;
    end else begin : g_pass
      assign w_s1_next = w_ext;
    end
  endgenerate

  fxp_clip #(
    .IN_W  (c_S1W),
    .OUT_W (c_OW)
  ) u_clip (
    .i_val (r_s1_val),
    .o_val (w_clip),
    .o_sat (w_clip_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_val    <= '0;
      r_s1_valid  <= 1'b0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_sat_now   <= 1'b0;
    end else if (w_adv) begin
      r_s1_val    <= w_s1_next;
      r_s1_valid  <= bus.in_valid;
      r_dout      <= w_clip;
      r_out_valid <= r_s1_valid;
      r_sat_now   <= w_clip_sat & r_s1_valid;
    end
  end

  // A clip loading on the same edge as clr_sat restarts the count at one.
  assign w_sat_load = w_adv & r_s1_valid & w_clip_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else if (w_sat_load) begin
      r_sat_flag <= 1'b1;
      if (clr_sat)
        r_sat_cnt <= 16'd1;
      else if (r_sat_cnt != 16'hFFFF)
        r_sat_cnt <= r_sat_cnt + 16'd1;
    end else if (clr_sat) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.out_valid = r_out_valid;
  assign bus.sat_now   = r_sat_now;
  assign sat_flag      = r_sat_flag;
  assign sat_cnt       = r_sat_cnt;
endmodule
`default_nettype wire

// File: tb/tb_requant_sat.sv
`default_nettype none
// ============================================================================
// tb_requant_sat : scoreboard bench for requant_sat, default formats
// Rev 1.0
// ============================================================================
module tb_requant_sat;
  localparam int IW = 25;
  localparam int OW = 20;
  localparam int SH = 4;
  localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (OW - 1));

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_sat = 1'b0;
  logic        sat_flag;
  logic [15:0] sat_cnt;

  requant_sat_if #(.IW(IW), .OW(OW)) bus ();

  requant_sat dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_sat  (clr_sat),
    .sat_flag (sat_flag),
    .sat_cnt  (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    bit            s;
    bit            clr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;
  bit   model_flag = 1'b0;
  bit   rand_ready = 1'b0;
  bit   force_ready = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-half-up to 1/2^SH granularity by floor division, then clamp to the output range.
  function automatic void ref_model(input logic [IW-1:0] d, output logic [OW-1:0] o, output bit s);
    longint x, num, q;
    x   = longint'($signed(d));
    num = x + (longint'(1) << (SH - 1));
    q   = num / (longint'(1) << SH);
    if (num < 0 && (num % (longint'(1) << SH)) != 0) q = q - 1;
    s = 1'b0;
    if (q > MAXV) begin q = MAXV; s = 1'b1; end
    else if (q < MINV) begin q = MINV; s = 1'b1; end
    o = q[OW-1:0];
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : force_ready;
    end
  end

  // Monitor: every output transfer pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output: got dout=0x%0h expected no output", bus.dout);
        end else begin
          e = sb.pop_front();
          if (e.clr) begin model_cnt = 0; model_flag = 1'b0; end
          if (e.s) begin
            model_flag = 1'b1;
            if (model_cnt < 65535) model_cnt++;
          end
          chk("dout", 64'(bus.dout), 64'(e.d));
          chk("sat_now", 64'(bus.sat_now), 64'(e.s));
          chk("sat_cnt", 64'(sat_cnt), 64'(model_cnt));
          chk("sat_flag", 64'(sat_flag), 64'(model_flag));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge after acceptance with in_valid still high.
  task automatic send(input logic [IW-1:0] x, input bit clr_at_load);
    logic [OW-1:0] o;
    bit            s;
    int            n;
    n = 0;
    bus.din      = x;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end else begin
      ref_model(x, o, s);
      sb.push_back('{d: o, s: s, clr: clr_at_load});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  function automatic logic [IW-1:0] rand_din();
    int r;
    r = int'($urandom_range(31));
    case ($urandom_range(3))
      0:       return IW'($urandom);
      1:       return IW'(r - 16);
      2:       return IW'(32'sh7FFFF0 + r);
      default: return IW'(-32'sh800000 - 16 + r);
    endcase
  endfunction

  initial begin
    logic [OW-1:0] o0;
    bit            s0;
    bus.din      = '0;
    bus.in_valid = 1'b0;

    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed values from the format definition.
    send(25'h0018000, 1'b0);
    send(25'h0000008, 1'b0);
    send(25'h0000007, 1'b0);
    send(25'h1FFFFF8, 1'b0);
    send(25'h1FFFFF7, 1'b0);
    send(25'h0C80000, 1'b0);
    send(25'h1380000, 1'b0);
    drain();
    chk("sat_cnt_directed", 64'(sat_cnt), 64'd2);
    chk("sat_flag_directed", 64'(sat_flag), 64'd1);

    // Backpressure: two values fill the pipe, third must wait.
    force_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send(25'h0001230, 1'b0);
    send(25'h1FFF000, 1'b0);
    ref_model(25'h0001230, o0, s0);
    bus.din = 25'h0002340;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_dout_hold", 64'(bus.dout), 64'(o0));
      @(negedge clk);
    end
    force_ready = 1'b1;
    send(25'h0002340, 1'b0);
    send(25'h0F00000, 1'b0);
    drain();

    // clr_sat coinciding with a clipped load, then alone.
    send(25'h0C80000, 1'b1);
    bus.in_valid = 1'b0;
    clr_sat = 1'b1;
    @(negedge clk);
    chk("clr_set_cnt", 64'(sat_cnt), 64'd1);
    chk("clr_set_flag", 64'(sat_flag), 64'd1);
    @(negedge clk);
    clr_sat = 1'b0;
    model_cnt = 0;
    model_flag = 1'b0;
    chk("clr_alone_cnt", 64'(sat_cnt), 64'd0);
    chk("clr_alone_flag", 64'(sat_flag), 64'd0);
    drain();

    // Mid-stream asynchronous reset with both stages holding data.
    send(25'h0C80000, 1'b0);
    send(25'h0011000, 1'b0);
    send(25'h0022000, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_dout", 64'(bus.dout), 64'd0);
    chk("mid_rst_sat_now", 64'(bus.sat_now), 64'd0);
    chk("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("mid_rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    sb.delete();
    model_cnt = 0;
    model_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_no_ghost", 64'(bus.out_valid), 64'd0);
    send(25'h0018000, 1'b0);
    drain();

    // Randomized traffic with random backpressure and bubbles.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end else begin
        send(rand_din(), 1'b0);
      end
    end
    drain();
    rand_ready = 1'b0;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
